scroll_ctrl: RTL and testbench

SCROLL_CTRL -- requirements
Module: scroll_ctrl

---
 rtl/scroll_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_scroll_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_ctrl.sv
// Scrolls an 8-character window over a 16-entry message buffer, one step every STEP_DIV clocks, pausing after each wrap.
// Outputs are registered and follow buffer/head changes by 1 clk; no backpressure, en only gates stepping.
module scroll_ctrl #(
    parameter int STEP_DIV    = 25000000,
    parameter int PAUSE_STEPS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       load,
    input  logic [4:0] msg_len,
    output logic [4:0] char0,
    output logic [4:0] char1,
    output logic [4:0] char2,
    output logic [4:0] char3,
    output logic [4:0] char4,
    output logic [4:0] char5,
    output logic [4:0] char6,
    output logic [4:0] char7,
    output logic [3:0] head,
    output logic       wrap
);
    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int PSE_W = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PSE_W-1:0] PSE_LAST = PSE_W'((PAUSE_STEPS > 0) ? PAUSE_STEPS - 1 : 0);
    localparam logic [4:0] BLANK = 5'd16;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       msg_buf [16];
    logic [4:0]       win     [8];
    logic [4:0]       len_r;
    logic [4:0]       len_in;
    logic [4:0]       len_eff;
    logic [4:0]       len_m1;
    logic [4:0]       head_ext;
    logic [3:0]       head_step;
    logic [PRE_W-1:0] pre_cnt;
    logic [PSE_W-1:0] pause_cnt;
    logic             tc;
    logic             pause_last;
    logic             head_bad;
    logic             wrap_hit;
    logic             step;
    logic             count_en;

    // Lengths above the buffer size saturate rather than truncate.
    assign len_in     = (msg_len > 5'd16) ? 5'd16 : msg_len;
    assign len_eff    = load ? len_in : len_r;
    assign len_m1     = len_r - 5'd1;
    assign head_ext   = {1'b0, head};
    assign tc         = (pre_cnt == PRE_LAST);
    assign pause_last = (pause_cnt == PSE_LAST);
    assign head_bad   = (head_ext >= len_r);
    assign wrap_hit   = dir ? (head == 4'd0) : (head_ext == len_m1);

    always_comb begin
        if (dir) begin
            head_step = (head == 4'd0) ? len_m1[3:0] : head - 4'd1;
        end else begin
            head_step = wrap_hit ? 4'd0 : head + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && len_eff != 5'd0) state_nxt = RUN;
            end
            RUN, HOLD: begin
                if (!en || len_eff == 5'd0) begin
                    state_nxt = IDLE;
                end else if (load) begin
                    state_nxt = RUN;
                end else if (step) begin
                    state_nxt = (wrap_hit && PAUSE_STEPS > 0) ? HOLD : RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // HOLD reuses the prescaler to time its pause periods; the last one ends with a step.
    always_comb begin
        count_en = 1'b0;
        step     = 1'b0;
        case (state)
            RUN: begin
                count_en = 1'b1;
                step     = tc;
            end
            HOLD: begin
                count_en = 1'b1;
                step     = tc && pause_last;
            end
            default: ;
        endcase
        if (load || !en || head_bad) step = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (load || !count_en || state_nxt == IDLE || tc) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_cnt <= '0;
        end else if (state != HOLD || state_nxt != HOLD) begin
            pause_cnt <= '0;
        end else if (tc) begin
            pause_cnt <= pause_last ? '0 : pause_cnt + PSE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 4'd0;
            len_r <= 5'd0;
            wrap  <= 1'b0;
        end else begin
            wrap <= step && wrap_hit;
            if (load) begin
                len_r <= len_in;
                head  <= 4'd0;
            end else if (head_bad) begin
                head <= 4'd0;
            end else if (step) begin
                head <= head_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) msg_buf[i] <= BLANK;
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    function automatic logic [3:0] win_idx(input logic [3:0] h, input logic [4:0] len,
                                           input logic [2:0] k);
        logic [4:0] sum;
        sum = {1'b0, h} + {2'b00, k};
        return 4'(sum % len);
    endfunction

    // Short messages repeat across the window because the index wraps modulo the length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) win[k] <= BLANK;
        end else begin
            for (int k = 0; k < 8; k++) begin
                win[7-k] <= (len_r == 5'd0) ? BLANK : msg_buf[win_idx(head, len_r, 3'(k))];
            end
        end
    end

    assign char0 = win[0];
    assign char1 = win[1];
    assign char2 = win[2];
    assign char3 = win[3];
    assign char4 = win[4];
    assign char5 = win[5];
    assign char6 = win[6];
    assign char7 = win[7];

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: cycle-level behavioural model compared every cycle plus directed literal checks.
module tb_scroll_ctrl;
    localparam int STEP  = 4;
    localparam int PAUSE = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       en      = 1'b0;
    logic       dir     = 1'b0;
    logic       wr_en   = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [4:0] wr_data = 5'd0;
    logic       load    = 1'b0;
    logic [4:0] msg_len = 5'd0;
    logic [4:0] char0, char1, char2, char3, char4, char5, char6, char7;
    logic [3:0] head;
    logic       wrap;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int n;

    scroll_ctrl #(.STEP_DIV(STEP), .PAUSE_STEPS(PAUSE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load(load), .msg_len(msg_len),
        .char0(char0), .char1(char1), .char2(char2), .char3(char3),
        .char4(char4), .char5(char5), .char6(char6), .char7(char7),
        .head(head), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model: message, length, displayed head, cycles into current step, pause bookkeeping.
    int m_buf [16];
    int m_chars [8];
    int m_len = 0, m_head = 0, m_cnt = 0, m_pause = 0;
    bit m_running = 0, m_holding = 0, m_wrap = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int  nlen;
        bit  do_step, wrapped;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_buf[i] = 16;
            for (int i = 0; i < 8; i++) m_chars[i] = 16;
            m_len = 0; m_head = 0; m_cnt = 0; m_pause = 0;
            m_running = 0; m_holding = 0; m_wrap = 0;
        end else begin
            for (int k = 0; k < 8; k++)
                m_chars[7-k] = (m_len == 0) ? 16 : m_buf[(m_head + k) % m_len];
            m_wrap = 0;
            if (wr_en) m_buf[wr_addr] = int'(wr_data);
            nlen = load ? ((msg_len > 16) ? 16 : int'(msg_len)) : m_len;
            if (load) begin
                m_head = 0; m_cnt = 0; m_pause = 0; m_holding = 0;
                m_running = en && (nlen != 0);
            end else if (!en || m_len == 0) begin
                m_running = 0; m_holding = 0; m_cnt = 0; m_pause = 0;
            end else if (!m_running) begin
                m_running = 1; m_cnt = 0;
            end else if (m_cnt < STEP - 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                do_step = 1;
                if (m_holding) begin
                    m_pause++;
                    if (m_pause < PAUSE) do_step = 0;
                    else begin m_holding = 0; m_pause = 0; end
                end
                if (do_step) begin
                    wrapped = dir ? (m_head == 0) : (m_head == m_len - 1);
                    m_head  = dir ? (m_head + m_len - 1) % m_len : (m_head + 1) % m_len;
                    if (wrapped) begin
                        m_wrap = 1;
                        if (PAUSE > 0) m_holding = 1;
                    end
                end
            end
            m_len = nlen;
        end
    end

    always @(negedge clk) begin : compare
        logic [44:0] act, exp;
        if (chk_on) begin
            act = {char7, char6, char5, char4, char3, char2, char1, char0, head, wrap};
            exp = {5'(m_chars[7]), 5'(m_chars[6]), 5'(m_chars[5]), 5'(m_chars[4]),
                   5'(m_chars[3]), 5'(m_chars[2]), 5'(m_chars[1]), 5'(m_chars[0]),
                   4'(m_head), m_wrap};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [39:0] pack8(input int c7, c6, c5, c4, c3, c2, c1, c0);
        return {5'(c7), 5'(c6), 5'(c5), 5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    function automatic logic [39:0] win_now();
        return {char7, char6, char5, char4, char3, char2, char1, char0};
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        tick(1);
        check("rst_chars", win_now(), pack8(16, 16, 16, 16, 16, 16, 16, 16));
        check("rst_head", head, 0);
        check("rst_wrap", wrap, 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Basic scroll, 10 digits, left.
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 5'(i);
            tick(1);
        end
        wr_en = 1'b0;
        msg_len = 5'd10; en = 1'b1; dir = 1'b0; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        check("basic_win0", win_now(), pack8(0, 1, 2, 3, 4, 5, 6, 7));
        tick(4);
        check("basic_win1", win_now(), pack8(1, 2, 3, 4, 5, 6, 7, 8));
        check("basic_head1", head, 1);
        n = 0;
        while (wrap !== 1'b1 && n < 60) begin tick(1); n++; end
        check("wrap_seen", wrap, 1);
        check("wrap_at", n, 35);
        check("wrap_head", head, 0);
        tick(1);
        check("wrap_one_clk", wrap, 0);
        n = 1;
        while (head == 4'd0 && n < 30) begin tick(1); n++; end
        check("hold_clks", n, 8);
        check("after_hold_head", head, 1);

        // en low freezes everything; re-enable restarts a full step period.
        en = 1'b0;
        tick(10);
        check("frozen_head", head, 1);
        check("frozen_char7", char7, 1);
        en = 1'b1;
        tick(4);
        check("reen_no_step", head, 1);
        tick(1);
        check("reen_step", head, 2);

        // Load coincident with terminal count.
        tick(3);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        check("load_tc_head", head, 0);
        check("load_tc_wrap", wrap, 0);
        tick(3);
        check("load_tc_hold", head, 0);
        tick(1);
        check("load_tc_step", head, 1);

        // Write to the entry under char7.
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 5'd15;
        tick(1);
        wr_en = 1'b0;
        check("wr_before", char7, 1);
        tick(1);
        check("wr_after", char7, 15);

        // Short message HELLO, scrolling right.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i);
            case (i)
                0: wr_data = 5'd10;
                1: wr_data = 5'd11;
                4: wr_data = 5'd0;
                default: wr_data = 5'd13;
            endcase
            tick(1);
        end
        wr_en = 1'b0;
        msg_len = 5'd5; dir = 1'b1; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        check("hello_win", win_now(), pack8(10, 11, 13, 13, 0, 10, 11, 13));
        tick(3);
        check("hello_head", head, 4);
        check("hello_wrap", wrap, 1);
        tick(1);
        check("hello_wrap_off", wrap, 0);

        // Oversized length clamps to 16.
        dir = 1'b0; msg_len = 5'd20; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        check("clamp_win", win_now(), pack8(10, 11, 13, 13, 0, 5, 6, 7));
        n = 1;
        while (wrap !== 1'b1 && n < 100) begin tick(1); n++; end
        check("clamp_wrap_at", n, 64);
        check("clamp_wrap_head", head, 0);

        // Empty message: blank, no stepping.
        msg_len = 5'd0; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(20);
        check("empty_head", head, 0);
        check("empty_win", win_now(), pack8(16, 16, 16, 16, 16, 16, 16, 16));

        // Asynchronous reset mid-run.
        msg_len = 5'd10; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(6);
        #1 rst_n = 1'b0;
        #1;
        check("arst_win", win_now(), pack8(16, 16, 16, 16, 16, 16, 16, 16));
        check("arst_head", head, 0);
        check("arst_wrap", wrap, 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_head", head, 0);
        check("post_rst_char7", char7, 16);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
